// File: rtl/arf_pkg.sv
// arf_pkg: op encoding, size limits and pointer sizing shared by arf operator nodes
package arf_pkg;
  typedef enum logic [3:0] {
    OP_REG, OP_IN, OP_OUT, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD, OP_SUB, OP_MUL, OP_BAD
  } op_e;
  localparam int MAX_INPUTS = 4;
  localparam int MAX_OUTPUTS = 8;
  function automatic op_e op_decode(input string s);
    return s == "reg"  ? OP_REG  :
           s == "in"   ? OP_IN   :
           s == "out"  ? OP_OUT  :
           s == "addi" ? OP_ADDI :
           s == "subi" ? OP_SUBI :
           s == "muli" ? OP_MULI :
           s == "add"  ? OP_ADD  :
           s == "sub"  ? OP_SUB  :
           s == "mul"  ? OP_MUL  : OP_BAD;
  endfunction
  function automatic bit op_is_nary(input op_e o);
    return o inside {OP_ADD, OP_SUB, OP_MUL};
  endfunction
  function automatic int ptr_width(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/elastic_op_fifo.sv
// elastic_op_fifo: depth-entry result FIFO whose head is broadcast to output_size consumers
module elastic_op_fifo
  import arf_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth = 2,
  parameter int output_size = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [data_width-1:0]             din,
  input  logic [output_size-1:0]            req_r,
  output logic [output_size-1:0]            ack_r,
  output logic [data_width-1:0]             dout,
  output logic [ptr_width(depth + 1)-1:0]   count
);
  localparam int PW = ptr_width(depth);
  localparam int CW = ptr_width(depth + 1);
  logic [data_width-1:0] mem [depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [output_size-1:0] taken, ack_next;
  logic nonempty, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign nonempty = count != '0;
  // a consumer may only be acked once per entry and never in back-to-back cycles
  assign ack_next = nonempty ? req_r & ~taken & ~ack_r : '0;
  assign pop = nonempty && &(taken | ack_next);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      taken <= '0;
      ack_r <= '0;
      dout <= '0;
    end else begin
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
      taken <= pop ? '0 : taken | ack_next;
      ack_r <= ack_next;
      dout <= |ack_next ? mem[rd_ptr] : dout;
    end
  end
endmodule

// File: rtl/elastic_async_operator.sv
// elastic_async_operator: N-operand req/ack arithmetic node feeding a broadcast elastic FIFO
// Define ELASTIC_ASYNC_OPERATOR_STATS_EN for saturating fire/stall counters.
module elastic_async_operator
  import arf_pkg::*;
#(
  parameter int    data_width = 32,
  parameter string op = "reg",
  parameter int    immediate = 0,
  parameter int    input_size = 1,
  parameter int    output_size = 1,
  parameter int    depth = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [input_size-1:0]            req_l,
  input  logic [input_size-1:0]            ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic [output_size-1:0]           req_r,
  output logic [output_size-1:0]           ack_r,
  output logic [data_width-1:0]            dout
`ifdef ELASTIC_ASYNC_OPERATOR_STATS_EN
  ,
  output logic [31:0]                      fire_count,
  output logic [31:0]                      full_stall_count,
  output logic [31:0]                      empty_stall_count
`endif
);
  localparam op_e OPC = op_decode(op);
  localparam logic [data_width-1:0] IMM = data_width'(immediate);
  localparam int CW = ptr_width(depth + 1);
  generate
    if (OPC == OP_BAD) begin : g_bad_op
      $error("elastic_async_operator: unsupported op %s", op);
    end
    if (op_is_nary(OPC) && input_size < 2) begin : g_bad_arity
      $error("elastic_async_operator: op %s needs at least two inputs", op);
    end
    if (input_size < 1 || input_size > MAX_INPUTS || output_size < 1 ||
        output_size > MAX_OUTPUTS || depth < 1) begin : g_bad_size
      $error("elastic_async_operator: size parameter out of range");
    end
  endgenerate
  logic [input_size-1:0] full;
  logic [data_width-1:0] slot [input_size];
  logic [data_width-1:0] acc, result;
  logic [CW-1:0] count;
  logic fifo_full, fire;
  assign fifo_full = count == CW'(depth);
  assign fire = &full && !fifo_full;
  // slots and their requests stay parked while the FIFO is full; no bypass on a same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= '0;
      req_l <= '0;
    end else begin
      for (int i = 0; i < input_size; i++) begin
        if (!full[i] && ack_l[i]) begin
          full[i] <= 1'b1;
          req_l[i] <= 1'b0;
        end else if (fire) begin
          full[i] <= 1'b0;
          req_l[i] <= 1'b0;
        end else begin
          req_l[i] <= !full[i];
        end
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < input_size; i++)
      if (!full[i] && ack_l[i]) slot[i] <= din[data_width*i +: data_width];
  always_comb begin
    acc = slot[0];
    for (int i = 1; i < input_size; i++)
      acc = OPC == OP_ADD ? acc + slot[i] :
            OPC == OP_SUB ? acc - slot[i] :
            OPC == OP_MUL ? acc * slot[i] : acc;
    result = OPC == OP_ADDI ? acc + IMM :
             OPC == OP_SUBI ? acc - IMM :
             OPC == OP_MULI ? acc * IMM : acc;
  end
  elastic_op_fifo #(
    .data_width(data_width),
    .depth(depth),
    .output_size(output_size)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(fire),
    .din(result),
    .req_r(req_r),
    .ack_r(ack_r),
    .dout(dout),
    .count(count)
  );
`ifdef ELASTIC_ASYNC_OPERATOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_count <= '0;
      full_stall_count <= '0;
      empty_stall_count <= '0;
    end else begin
      if (fire && !(&fire_count)) fire_count <= fire_count + 1'b1;
      if (&full && fifo_full && !(&full_stall_count)) full_stall_count <= full_stall_count + 1'b1;
      if (|req_r && count == '0 && !(&empty_stall_count)) empty_stall_count <= empty_stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: doc/elastic_async_operator.md
# elastic_async_operator

Parametrised successor to the dataflow operator node used inside generated `arf` graphs. Pulls N operands over per-input req/ack channels, applies a compile-time arithmetic op, and stores results in an internal DEPTH-entry elastic FIFO. Results are broadcast to M downstream consumers, each handshaking independently. With DEPTH>1, graphs can absorb skew between paths without explicit `reg` nodes.

## Interface
- `data_width`, 32, operand/result width
- `op`, "reg", one of "reg","in","out","addi","subi","muli","add","sub","mul"
- `immediate`, 0, constant for *i ops (truncated to data_width)
- `input_size`, 1, operand count N, 1..4
- `output_size`, 1, consumer count M, 1..8
- `depth`, 2, result FIFO entries, >=1, any integer
- `clk` in 1, single clock, all logic on posedge
- `rst_n` in 1, reset, synchronous and active-low
- `req_l` out N, per-input operand request to upstream
- `ack_l` in N, per-input upstream ack pulse; `din` slice valid same cycle
- `din` in data_width*N, operand i at bits [data_width*(i+1)-1 : data_width*i]
- `req_r` in M, per-consumer result request
- `ack_r` out M, per-consumer one-cycle result ack
- `dout` out data_width, FIFO head value, valid whenever any `ack_r` bit is 1

## Operation
- Reset (`rst_n`=0 at posedge): `req_l`=0, `ack_r`=0, `dout`=0, all operand slots empty, FIFO empty, taken bits cleared. In-flight operands are discarded; mid-operation reset needs no recovery.
- Input side, per input i:
  - `req_l[i]` rises the cycle after slot i is empty.
  - On a posedge with `ack_l[i]`=1, `din` slice i is captured synchronously into slot i, the slot is marked full, and `req_l[i]` falls.
  - `ack_l[i]` is ignored while slot i is full.
- Fire: when all N slots are full and FIFO count < depth, the result is pushed and all slots are cleared in the same cycle.
- FIFO full: operands are held and `req_l` stays low until space frees. There is no bypass when full, even if a pop occurs in the same cycle.
- Op semantics, all modulo 2^data_width:
  - reg/in/out: d0.
  - add: d0+d1+…
  - sub: d0-d1-…
  - mul: d0*d1*…
  - addi/subi/muli: d0 op immediate.
- Output side, per consumer j:
  - `ack_r[j]` pulses when FIFO non-empty, `req_r[j]`=1, `taken[j]`=0, and `ack_r[j]` was 0 the previous cycle.
  - On the pulse, `taken[j]` is set.
- Pop: the head retires in the cycle where every taken bit, including acks issued that cycle, is 1. All taken bits then clear.
- Push and pop in the same cycle are allowed when count < depth. Pointers wrap from depth-1 to 0.
- Invalid op, or N-input op with N=1: elaboration error.

## Timing
- Operand latency: `ack_l` at edge t → slot full after t. The earliest fire is at edge t+1. The result is at the FIFO head after t+1, and the earliest `ack_r` is at edge t+2.
- Input throughput: one operand set per 2 cycles (req drop/raise), matching the codebase producer pattern.
- Output throughput: one ack per 2 cycles per consumer. The slowest consumer gates the pop.
- `dout` is registered from the head and stable for the full ack cycle.

## Configuration
- `ELASTIC_ASYNC_OPERATOR_STATS_EN` defined: adds three 32-bit outputs.
  - `fire_count`: increments per fire.
  - `full_stall_count`: cycles with all slots full and FIFO full.
  - `empty_stall_count`: cycles with any `req_r` high and FIFO empty.
  - All three reset to 0 and saturate at 2^32-1.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `arf_pkg`:
  - op encoding localparams (string→enum)
  - limits MAX_INPUTS=4, MAX_OUTPUTS=8
  - a pointer-width function clog2(depth) with minimum 1
- Sub-module `elastic_op_fifo`: depth-entry storage, wrap pointers, count, and broadcast taken-bit pop logic.
- The top level holds the operand slots, req logic and operator datapath.

## Test plan
- N=2, "add", depth=2, M=1: feed 5 and 7, consumer always requesting → one `ack_r` pulse with `dout`=12 exactly two edges after the last `ack_l`.
- "sub", N=3, data_width=8: operands 1,2,3 → `dout`=252 (wraparound).
- depth=2, consumer idle: present 3 operand sets → two fires, third set held with `req_l`=0. Enable consumer → results in order, then third fires.
- M=3, consumers with requests delayed 0/4/9 cycles: head persists until the third ack, each consumer gets exactly one ack per entry, then the next entry appears.
- Assert `rst_n`=0 with FIFO holding 1 entry and one slot full → after release, FIFO empty, `req_l` all 1 one cycle later, no stale `ack_r`.
- Stats macro on: 10 results with consumer stalled 6 cycles while full → `fire_count`=10 and `full_stall_count` equal to the stalled cycles counted by the bench.
